// File: rtl/debounce_switch_bank.sv
// Multi-channel switch debouncer: 2-flop synchroniser plus per-channel persistence filter with press/release pulses.
// Optional long-press detection is built only when DEBOUNCE_LONGPRESS_EN is defined; otherwise o_long is tied low.
module debounce_switch_bank #(
  parameter int                NUM_CH         = 4,
  parameter int                DEBOUNCE_LIMIT = 250000,
  parameter logic [NUM_CH-1:0] INIT_STATE     = '0,
  parameter int                LONG_LIMIT     = 25000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_switch,
  output logic [NUM_CH-1:0] o_switch,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_long
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0]            sync1_q, sync2_q;
  logic [NUM_CH-1:0]            state_q, state_d;
  logic [NUM_CH-1:0]            rise_q, rise_d;
  logic [NUM_CH-1:0]            fall_q, fall_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronised level disagrees with the
  // accepted state; the final mismatching sample commits the new level.
  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sync2_q[k] == state_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        cnt_d[k]   = '0;
        state_d[k] = sync2_q[k];
        rise_d[k]  = sync2_q[k];
        fall_d[k]  = ~sync2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= INIT_STATE;
      sync2_q <= INIT_STATE;
      state_q <= INIT_STATE;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_switch;
      sync2_q <= sync1_q;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_switch = state_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int               HOLD_W   = $clog2(LONG_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_LIMIT);

  logic [NUM_CH-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0]             long_q, long_d;

  // Hold counter parks at HOLD_MAX so the pulse fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!state_q[k]) begin
        hold_d[k] = '0;
      end else if (hold_q[k] != HOLD_MAX) begin
        hold_d[k] = hold_q[k] + 1'b1;
        long_d[k] = (hold_d[k] == HOLD_MAX);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = '0;
`endif

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Directed bench for debounce_switch_bank (NUM_CH=4, DEBOUNCE_LIMIT=4, INIT_STATE=0, LONG_LIMIT=16).
module tb_debounce_switch_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0000;
  logic [3:0] o_switch, o_rise, o_fall, o_long;
  int         errors = 0;
  int         checks = 0;

  debounce_switch_bank #(
    .NUM_CH(4), .DEBOUNCE_LIMIT(4), .INIT_STATE(4'b0000), .LONG_LIMIT(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_switch(sw),
    .o_switch(o_switch), .o_rise(o_rise), .o_fall(o_fall), .o_long(o_long)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; sw = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (o_switch !== 4'b0000) begin errors++; $display("FAIL reset_switch got=%b exp=0000", o_switch); end
    checks++; if (o_rise !== 4'b0000) begin errors++; $display("FAIL reset_rise got=%b exp=0000", o_rise); end
    checks++; if (o_fall !== 4'b0000) begin errors++; $display("FAIL reset_fall got=%b exp=0000", o_fall); end
    checks++; if (o_long !== 4'b0000) begin errors++; $display("FAIL reset_long got=%b exp=0000", o_long); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ((o_rise | o_fall) !== 4'b0000) begin errors++; $display("FAIL post_reset_pulse rise=%b fall=%b exp=0000", o_rise, o_fall); end
  endtask

  // Apply a new level and watch n cycles; new level expected at cycle 6 with matching pulses.
  task automatic test_transition(input string name, input logic [3:0] from_v, input logic [3:0] to_v, input int n);
    logic [3:0] e_sw, e_r, e_f;
    sw = to_v;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e_sw = (c >= 6) ? to_v : from_v;
      e_r  = (c == 6) ? (to_v & ~from_v) : 4'b0000;
      e_f  = (c == 6) ? (from_v & ~to_v) : 4'b0000;
      checks++; if (o_switch !== e_sw) begin errors++; $display("FAIL %s_switch cyc=%0d got=%b exp=%b", name, c, o_switch, e_sw); end
      checks++; if (o_rise !== e_r) begin errors++; $display("FAIL %s_rise cyc=%0d got=%b exp=%b", name, c, o_rise, e_r); end
      checks++; if (o_fall !== e_f) begin errors++; $display("FAIL %s_fall cyc=%0d got=%b exp=%b", name, c, o_fall, e_f); end
    end
  endtask

  task automatic test_glitch();
    sw = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) sw = 4'b0000;
      checks++; if (o_switch !== 4'b0000) begin errors++; $display("FAIL glitch_switch cyc=%0d got=%b exp=0000", c, o_switch); end
      checks++; if ((o_rise | o_fall) !== 4'b0000) begin errors++; $display("FAIL glitch_pulse cyc=%0d rise=%b fall=%b exp=0000", c, o_rise, o_fall); end
    end
  endtask

  // Exactly DEBOUNCE_LIMIT high samples: accepted, then released four cycles later.
  task automatic test_exact_limit();
    logic [3:0] e_sw, e_r, e_f;
    sw = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) sw = 4'b0000;
      e_sw = (c >= 6 && c <= 9) ? 4'b0010 : 4'b0000;
      e_r  = (c == 6)  ? 4'b0010 : 4'b0000;
      e_f  = (c == 10) ? 4'b0010 : 4'b0000;
      checks++; if (o_switch !== e_sw) begin errors++; $display("FAIL exact_switch cyc=%0d got=%b exp=%b", c, o_switch, e_sw); end
      checks++; if (o_rise !== e_r) begin errors++; $display("FAIL exact_rise cyc=%0d got=%b exp=%b", c, o_rise, e_r); end
      checks++; if (o_fall !== e_f) begin errors++; $display("FAIL exact_fall cyc=%0d got=%b exp=%b", c, o_fall, e_f); end
    end
  endtask

  task automatic test_reset_mid();
    sw = 4'b1000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (o_switch !== 4'b0000 || (o_rise | o_fall) !== 4'b0000) begin
        errors++; $display("FAIL midcount_pre cyc=%0d sw=%b rise=%b fall=%b exp=0000", c, o_switch, o_rise, o_fall); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (o_switch !== 4'b0000) begin errors++; $display("FAIL midcount_rst_switch got=%b exp=0000", o_switch); end
    checks++; if ((o_rise | o_fall) !== 4'b0000) begin errors++; $display("FAIL midcount_rst_pulse rise=%b fall=%b exp=0000", o_rise, o_fall); end
    test_transition("midcount_after", 4'b0000, 4'b1000, 8);
  endtask

  task automatic test_long();
    logic [3:0] e_l;
    for (int p = 0; p < 2; p++) begin
      sw = 4'b0001;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
`ifdef DEBOUNCE_LONGPRESS_EN
        e_l = (c == 22) ? 4'b0001 : 4'b0000;
`else
        e_l = 4'b0000;
`endif
        checks++; if (o_switch !== ((c >= 6) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL long_switch press=%0d cyc=%0d got=%b", p, c, o_switch); end
        checks++; if (o_rise !== ((c == 6) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL long_rise press=%0d cyc=%0d got=%b", p, c, o_rise); end
        checks++; if (o_long !== e_l) begin errors++; $display("FAIL long_pulse press=%0d cyc=%0d got=%b exp=%b", p, c, o_long, e_l); end
      end
      sw = 4'b0000;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        checks++; if (o_long !== 4'b0000) begin errors++; $display("FAIL long_release press=%0d cyc=%0d got=%b exp=0000", p, c, o_long); end
        checks++; if (o_fall !== ((c == 6) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL long_fall press=%0d cyc=%0d got=%b", p, c, o_fall); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_transition("single_rise", 4'b0000, 4'b0001, 8);
    test_transition("single_fall", 4'b0001, 4'b0000, 8);
    test_glitch();
    test_exact_limit();
    test_transition("multi_rise", 4'b0000, 4'b1010, 8);
    test_transition("ch2_rise", 4'b1010, 4'b1110, 8);
    test_transition("ch2_fall", 4'b1110, 4'b1010, 8);
    test_transition("all_release", 4'b1010, 4'b0000, 8);
    test_reset_mid();
    test_transition("ch3_release", 4'b1000, 4'b0000, 8);
    test_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
